// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with CTS flow control and a power-of-two byte FIFO.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int BAUD_COUNT = 645,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [7:0]                  data_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic                        cts_n_in,
    output logic                        tx_out,
    output logic                        busy_out,
    output logic [$clog2(FIFO_DEPTH):0] count_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUD_COUNT + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            frame_q, frame_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic push, pop, bit_done, can_start;

    assign ready_out = count_q < CW'(FIFO_DEPTH);
    assign push      = valid_in && ready_out;
    assign bit_done  = baud_q == BW'(BAUD_COUNT - 1);
    assign can_start = (count_q != '0) && !cts_n_in;

    // Frame sequencer; the head byte is popped into the shift register whenever a frame starts.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (can_start) begin
                    state_d = START;
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (can_start) begin
                        state_d = START;
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is driven from the current state, so tx lags the state register by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^shift_q;
`endif
            default: tx_d = 1'b1;
        endcase
        frame_d = state_q != IDLE;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            frame_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            frame_q  <= frame_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; pointers and count alone define which slots hold valid bytes.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign tx_out    = tx_q;
    assign count_out = count_q;
    assign busy_out  = frame_q || (state_q != IDLE) || (count_q != '0);

endmodule
